imem_boot_loader: RTL and testbench

Upstream boot stage for the single-cycle ARM core. It receives a program as a byte stream over a valid/ready interface and assembles little-endian 32-bit words. It writes those words into the instruction memory write port and holds the core in reset until a checksummed load completes. On success it releases cpu_reset; on any protocol or checksum error it keeps the core in reset and flags the error.

---
 rtl/imem_boot_loader_if.sv | 22 ++
 rtl/imem_boot_loader.sv | 74 +++++++
 tb/tb_imem_boot_loader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: boot byte stream, imem write port and core-control signals of the boot loader
interface imem_boot_loader_if #(parameter int ADDR_W = 6);
  logic start;
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic cpu_reset;
  logic busy;
  logic done;
  logic error;
  modport slave (
    input start, in_valid, in_data,
    output in_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, busy, done, error
  );
  modport master (
    output start, in_valid, in_data,
    input in_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, busy, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a checksummed byte stream into imem and releases the core on success
module imem_boot_loader #(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6
) (
  input logic clk,
  input logic reset,
  imem_boot_loader_if.slave bus
);
  localparam int CW = ADDR_W + 1;
  typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;
  state_t state, state_n;
  logic [CW-1:0] n, word_idx;
  logic [1:0] byte_idx;
  logic [7:0] acc;
  logic [23:0] asm_r;
  logic xfer, word_end, last_word, bad_hdr, hold_done;
  assign bus.in_ready = state inside {HDR, DATA, CSUM};
  assign bus.busy = bus.in_ready;
  assign xfer = bus.in_valid & bus.in_ready;
  assign word_end = xfer && state == DATA && byte_idx == 2'd3;
  assign last_word = word_idx + CW'(1) == n;
  assign bad_hdr = bus.in_data == 8'd0 || {1'b0, bus.in_data} > 9'(DEPTH);
  assign hold_done = state == DONE && !bus.start;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = bus.start ? HDR : IDLE;
      HDR: state_n = xfer ? (bad_hdr ? ERR : DATA) : HDR;
      DATA: state_n = word_end && last_word ? CSUM : DATA;
      CSUM: state_n = xfer ? (bus.in_data == acc ? DONE : ERR) : CSUM;
      default: state_n = bus.start ? HDR : state;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      n <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      acc <= '0;
      asm_r <= '0;
      bus.imem_we <= 1'b0;
      bus.imem_waddr <= '0;
      bus.imem_wdata <= '0;
      bus.cpu_reset <= 1'b1;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
    end else begin
      state <= state_n;
      bus.imem_we <= word_end;
      bus.done <= hold_done;
      bus.error <= state == ERR && !bus.start;
      bus.cpu_reset <= !hold_done;
      if (xfer && state == HDR) begin
        n <= CW'(bus.in_data);
        word_idx <= '0;
        byte_idx <= '0;
        acc <= '0;
      end
      if (xfer && state == DATA) begin
        acc <= acc ^ bus.in_data;
        byte_idx <= byte_idx + 2'd1;
        asm_r <= {bus.in_data, asm_r[23:8]};
      end
      // bytes arrive LSB first, so the first three have shifted down into asm_r by the 4th
      if (word_end) begin
        bus.imem_waddr <= word_idx[ADDR_W-1:0];
        bus.imem_wdata <= {bus.in_data, asm_r};
        word_idx <= word_idx + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed checks of the boot loader stream protocol, imem writes and core release
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  logic [31:0] wmem [64];
  logic [7:0] x;
  imem_boot_loader_if #(.ADDR_W(6)) bus();
  imem_boot_loader #(.DEPTH(64), .ADDR_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_cnt++;
      wmem[bus.imem_waddr] = bus.imem_wdata;
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic pulse_start;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input bit gap);
    if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = b;
    for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) @(negedge clk);
    chk("in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send(w[8*i +: 8], gap);
      x ^= w[8*i +: 8];
    end
  endtask
  initial begin
    int base;
    logic [31:0] w;
    logic [31:0] exp64 [64];
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    x = 8'h00;
    tick(2);
    chk("rst_cpu_reset", bus.cpu_reset, 1);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_we", bus.imem_we, 0);
    chk("rst_waddr", bus.imem_waddr, 0);
    chk("rst_wdata", bus.imem_wdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    reset = 1'b0;
    tick(1);
    chk("idle_in_ready", bus.in_ready, 0);
    // Test 1: happy path, one word
    base = wr_cnt;
    pulse_start;
    chk("t1_busy", bus.busy, 1);
    chk("t1_in_ready", bus.in_ready, 1);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h8F, 0);
    send(8'hE2, 0);
    send(8'h6D, 0);
    chk("t1_done_lat", bus.done, 0);
    chk("t1_cpu_reset_lat", bus.cpu_reset, 1);
    tick(1);
    chk("t1_done", bus.done, 1);
    chk("t1_cpu_reset", bus.cpu_reset, 0);
    chk("t1_error", bus.error, 0);
    chk("t1_in_ready", bus.in_ready, 0);
    chk("t1_writes", wr_cnt - base, 1);
    chk("t1_word0", wmem[0], 32'hE28F0000);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    tick(3);
    chk("bp_done_hold", bus.done, 1);
    chk("bp_no_write", wr_cnt - base, 1);
    bus.in_valid = 1'b0;
    // Test 2: bad checksum
    pulse_start;
    chk("t2_restart_cpu_reset", bus.cpu_reset, 1);
    chk("t2_restart_done", bus.done, 0);
    base = wr_cnt;
    send(8'h01, 0);
    x = 8'h00;
    send_word(32'hE28F0000, 0);
    send(8'h6C, 0);
    tick(1);
    chk("t2_error", bus.error, 1);
    chk("t2_cpu_reset", bus.cpu_reset, 1);
    chk("t2_done", bus.done, 0);
    chk("t2_busy", bus.busy, 0);
    chk("t2_writes", wr_cnt - base, 1);
    // Test 3: header bounds
    base = wr_cnt;
    pulse_start;
    send(8'h00, 0);
    tick(1);
    chk("t3_h00_error", bus.error, 1);
    chk("t3_h00_busy", bus.busy, 0);
    chk("t3_h00_writes", wr_cnt - base, 0);
    pulse_start;
    send(8'h41, 0);
    tick(1);
    chk("t3_h41_error", bus.error, 1);
    chk("t3_h41_busy", bus.busy, 0);
    pulse_start;
    send(8'h40, 0);
    x = 8'h00;
    for (int k = 0; k < 64; k++) begin
      for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'((4 * k + j) * 7 + 3);
      exp64[k] = w;
      send_word(w, 0);
    end
    send(x, 0);
    tick(1);
    chk("t3_full_done", bus.done, 1);
    chk("t3_full_error", bus.error, 0);
    chk("t3_full_writes", wr_cnt - base, 64);
    for (int k = 0; k < 64; k++) chk($sformatf("t3_word%0d", k), wmem[k], exp64[k]);
    // Test 4: random gaps in in_valid
    base = wr_cnt;
    pulse_start;
    send(8'h02, 1);
    x = 8'h00;
    send_word(32'h11223344, 1);
    send_word(32'hA5B6C7D8, 1);
    send(x, 1);
    tick(1);
    chk("t4_done", bus.done, 1);
    chk("t4_writes", wr_cnt - base, 2);
    chk("t4_word0", wmem[0], 32'h11223344);
    chk("t4_word1", wmem[1], 32'hA5B6C7D8);
    // Test 5: reset mid-DATA
    pulse_start;
    base = wr_cnt;
    send(8'h03, 0);
    send_word(32'h01020304, 0);
    send(8'h05, 0);
    send(8'h06, 0);
    reset = 1'b1;
    #1;
    chk("t5_rst_cpu_reset", bus.cpu_reset, 1);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_in_ready", bus.in_ready, 0);
    tick(2);
    reset = 1'b0;
    tick(3);
    chk("t5_idle_busy", bus.busy, 0);
    chk("t5_idle_done", bus.done, 0);
    chk("t5_writes", wr_cnt - base, 1);
    chk("t5_partial_word", wmem[0], 32'h01020304);
    pulse_start;
    send(8'h01, 0);
    x = 8'h00;
    send_word(32'hDEADBEEF, 0);
    send(x, 0);
    tick(1);
    chk("t5_reload_done", bus.done, 1);
    chk("t5_reload_cpu_reset", bus.cpu_reset, 0);
    chk("t5_reload_word0", wmem[0], 32'hDEADBEEF);
    chk("t5_reload_writes", wr_cnt - base, 2);
    // Test 6: start during busy ignored, then restart from DONE
    pulse_start;
    base = wr_cnt;
    send(8'h02, 0);
    x = 8'h00;
    send_word(32'hCAFEF00D, 0);
    pulse_start;
    chk("t6_busy_after_start", bus.busy, 1);
    send_word(32'h0BADC0DE, 0);
    send(x, 0);
    tick(1);
    chk("t6_done", bus.done, 1);
    chk("t6_writes", wr_cnt - base, 2);
    chk("t6_word0", wmem[0], 32'hCAFEF00D);
    chk("t6_word1", wmem[1], 32'h0BADC0DE);
    pulse_start;
    chk("t6_restart_cpu_reset", bus.cpu_reset, 1);
    chk("t6_restart_done", bus.done, 0);
    chk("t6_restart_busy", bus.busy, 1);
    send(8'h01, 0);
    x = 8'h00;
    send_word(32'h12345678, 0);
    send(x, 0);
    tick(1);
    chk("t6_reload_done", bus.done, 1);
    chk("t6_reload_cpu_reset", bus.cpu_reset, 0);
    chk("t6_reload_word0", wmem[0], 32'h12345678);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
